mat_adj_fetch_ctrl: RTL and testbench
=====================================

MAT_ADJ_FETCH_CTRL -- requirements
Module: mat_adj_fetch_ctrl

Interface
REQ-001 SHALL have parameter COLUMNS, default 180, meaning image width in pixels.
REQ-002 SHALL have parameter ROWS, default 120, meaning image height in pixels.
REQ-003 SHALL have parameter PIX_W, default 8, meaning frame-buffer pixel width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk, input, 1, meaning system clock; all state rising-edge.
REQ-006 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, meaning one-cycle fetch request.
REQ-008 SHALL have port ref_row, input, 7, meaning reference pixel row.
REQ-009 SHALL have port ref_col, input, 8, meaning reference pixel column.
REQ-010 SHALL have port fb_rd_en, output, 1, meaning frame-buffer read strobe.
REQ-011 SHALL have port fb_addr, output, 15, meaning frame-buffer read address.
REQ-012 SHALL have port fb_rd_data, input, PIX_W, meaning read data, valid one cycle after fb_rd_en.
REQ-013 SHALL have port nbr_data, output, 8*PIX_W, meaning neighbour k in bits [PIX_W*k+PIX_W-1 : PIX_W*k].
REQ-014 SHALL have port nbr_valid, output, 8, meaning bit k high if neighbour k lies inside the frame.
REQ-015 SHALL have port busy, output, 1, meaning fetch in progress.
REQ-016 SHALL have port done, output, 1, meaning one-cycle completion pulse.
REQ-017 SHALL have port err, output, 1, meaning last request had row>=ROWS or col>=COLUMNS.

Function
REQ-018 SHALL compute ref = ref_row*COLUMNS + ref_col (15-bit, unsigned), registered with ref_row/ref_col when start is accepted.
REQ-019 SHALL order neighbours k=0..7 as N, NE, E, SE, S, SW, W, NW with offsets -C, -C+1, +1, +C+1, +C, +C-1, -1, -C-1 (C=COLUMNS).
REQ-020 SHALL mark neighbour k valid only if its row is in [0,ROWS-1] and its column is in [0,COLUMNS-1]; no column wrap to adjacent rows.
REQ-021 SHALL accept start only in state IDLE; start while busy SHALL be ignored with no effect.
REQ-022 SHALL implement states IDLE -> ISSUE (8 cycles, index 0..7) -> DRAIN (1 cycle) -> DONE (1 cycle) -> IDLE.
REQ-023 SHALL, in ISSUE cycle k, assert fb_rd_en with fb_addr = address of neighbour k if valid, else hold fb_rd_en low; skipped neighbours still consume one cycle.
REQ-024 SHALL capture fb_rd_data into slot k in the cycle after issuing index k; slots of invalid neighbours SHALL be written 0.
REQ-025 SHALL assert done for exactly the DONE cycle, 10 cycles after the accepting edge; busy SHALL be high from the cycle after acceptance through the DONE cycle.
REQ-026 SHALL, on out-of-range row/col, skip ISSUE/DRAIN, go directly to DONE, set err=1, nbr_valid=0, nbr_data=0, issue no reads.
REQ-027 SHALL hold nbr_data, nbr_valid and err stable from done until the next accepted start.
REQ-028 SHALL drive fb_addr = 0 whenever fb_rd_en is low.

Reset
REQ-029 SHALL, on reset_n low at any time, enter IDLE and clear fb_rd_en, fb_addr, nbr_data, nbr_valid, busy, done, err to 0.
REQ-030 SHALL discard any frame-buffer data returning after a mid-fetch reset; no done pulse for the aborted request.

Structure
REQ-031 SHALL take COLUMNS, ROWS, address width 15, PIX_W and neighbour count 8 from the shared project constants package.
REQ-032 SHALL instantiate the existing adjacency address calculator Mat_AddrCal (ref address, 3-bit index -> FB address) as its sole sub-module.

Verification
REQ-033 Interior: start row=10,col=20 -> reads at 1640,1641,1821,2001,2000,1999,1819,1639 on 8 consecutive cycles, nbr_valid=8'hFF, done 10 cycles after start.
REQ-034 Corner: row=0,col=0 -> reads only at 1,181,180, nbr_valid=8'b00011100, other slots 0, done still at cycle 10.
REQ-035 Corner: row=119,col=179 (ref 21599) -> reads at 21419,21598,21418, nbr_valid=8'b11000001.
REQ-036 Error: row=120,col=0 -> no fb_rd_en, done 1 cycle after acceptance, err=1, nbr_valid=0.
REQ-037 Busy: second start 3 cycles after the first -> ignored, single done, results match the first request.
REQ-038 Reset: reset_n low during ISSUE index 4 -> all outputs 0 immediately, no done, next start completes normally.

Source files
------------

// File: rtl/mat_adj_fetch_ctrl_pkg.sv
// Shared project constants and types for the adjacency fetch controller.
// Provides frame geometry defaults, address/pixel widths, neighbour count,
// the fetch FSM state type, the neighbour direction order, and a helper that
// computes which neighbours of a pixel lie inside the frame.
package mat_adj_fetch_ctrl_pkg;

    localparam int unsigned COLUMNS = 180;
    localparam int unsigned ROWS    = 120;
    localparam int unsigned ADDR_W  = 15;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned NBR_CNT = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned ROW_W   = 7;
    localparam int unsigned COL_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } fetch_state_t;

    // Neighbour order, clockwise starting at north.
    typedef enum logic [IDX_W-1:0] {
        NBR_N  = 3'd0,
        NBR_NE = 3'd1,
        NBR_E  = 3'd2,
        NBR_SE = 3'd3,
        NBR_S  = 3'd4,
        NBR_SW = 3'd5,
        NBR_W  = 3'd6,
        NBR_NW = 3'd7
    } nbr_dir_t;

    // Bit k set when neighbour k of (row, col) is inside a rows x cols frame.
    // Edge columns never borrow pixels from the adjacent row.
    function automatic logic [NBR_CNT-1:0] nbr_mask(
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] col,
        input int unsigned      rows,
        input int unsigned      cols
    );
        logic has_n;
        logic has_s;
        logic has_w;
        logic has_e;
        logic [NBR_CNT-1:0] mask;
        has_n = (row != '0);
        has_s = ((32'(row) + 32'd1) < rows);
        has_w = (col != '0);
        has_e = ((32'(col) + 32'd1) < cols);
        mask         = '0;
        mask[NBR_N]  = has_n;
        mask[NBR_NE] = has_n & has_e;
        mask[NBR_E]  = has_e;
        mask[NBR_SE] = has_s & has_e;
        mask[NBR_S]  = has_s;
        mask[NBR_SW] = has_s & has_w;
        mask[NBR_W]  = has_w;
        mask[NBR_NW] = has_n & has_w;
        return mask;
    endfunction

endpackage

// File: rtl/mat_adj_fetch_ctrl_addrcal.sv
// Mat_AddrCal: adjacency address calculator.
// Converts a reference frame-buffer address and a neighbour index (0..7,
// N, NE, E, SE, S, SW, W, NW) into the neighbour's frame-buffer address.
// Purely combinational; the result is meaningless for neighbours outside
// the frame, which the caller masks.
//   ref_addr : reference pixel address (row*COLUMNS + col)
//   idx      : neighbour index
//   addr     : neighbour address
module Mat_AddrCal
    import mat_adj_fetch_ctrl_pkg::*;
#(
    parameter int unsigned COLUMNS = mat_adj_fetch_ctrl_pkg::COLUMNS
)(
    input  logic [ADDR_W-1:0] ref_addr,
    input  logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] C   = ADDR_W'(COLUMNS);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    always_comb begin
        addr = ref_addr;
        case (nbr_dir_t'(idx))
            NBR_N:  addr = ref_addr - C;
            NBR_NE: addr = ref_addr - C + ONE;
            NBR_E:  addr = ref_addr + ONE;
            NBR_SE: addr = ref_addr + C + ONE;
            NBR_S:  addr = ref_addr + C;
            NBR_SW: addr = ref_addr + C - ONE;
            NBR_W:  addr = ref_addr - ONE;
            NBR_NW: addr = ref_addr - C - ONE;
            default: addr = ref_addr;
        endcase
    end

endmodule

// File: rtl/mat_adj_fetch_ctrl.sv
// mat_adj_fetch_ctrl: fetches the 8 neighbours of a reference pixel from a
// frame buffer with one-cycle read latency.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   start, ref_row/ref_col: one-cycle request with reference pixel position
//   fb_rd_en, fb_addr     : frame-buffer read strobe and address
//   fb_rd_data            : read data, valid the cycle after fb_rd_en
//   nbr_data, nbr_valid   : neighbour pixels (slot k) and in-frame flags
//   busy, done, err       : fetch in progress, completion pulse, range error
// Timeline after the accepting edge: 8 ISSUE cycles (one per neighbour,
// skipped neighbours still take their cycle), 1 DRAIN cycle for the last
// read to return, 1 DONE cycle. Out-of-range requests jump straight to DONE.
module mat_adj_fetch_ctrl
    import mat_adj_fetch_ctrl_pkg::*;
#(
    parameter int unsigned COLUMNS = mat_adj_fetch_ctrl_pkg::COLUMNS,
    parameter int unsigned ROWS    = mat_adj_fetch_ctrl_pkg::ROWS,
    parameter int unsigned PIX_W   = mat_adj_fetch_ctrl_pkg::PIX_W
)(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [ROW_W-1:0]           ref_row,
    input  logic [COL_W-1:0]           ref_col,
    output logic                       fb_rd_en,
    output logic [ADDR_W-1:0]          fb_addr,
    input  logic [PIX_W-1:0]           fb_rd_data,
    output logic [NBR_CNT*PIX_W-1:0]   nbr_data,
    output logic [NBR_CNT-1:0]         nbr_valid,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    fetch_state_t              state;
    fetch_state_t              state_nxt;
    logic [IDX_W-1:0]          idx;
    logic [IDX_W-1:0]          idx_nxt;

    logic [ADDR_W-1:0]         ref_addr;
    logic [NBR_CNT-1:0]        mask;
    logic                      err_q;
    logic [NBR_CNT*PIX_W-1:0]  data_q;

    // Slot written by the capture stage: the index issued one cycle earlier.
    logic                      cap_en;
    logic [IDX_W-1:0]          cap_idx;

    logic                      accept;
    logic                      in_range;
    logic                      rd;
    logic [ADDR_W-1:0]         ref_calc;
    logic [ADDR_W-1:0]         calc_addr;

    assign accept   = (state == ST_IDLE) && start;
    assign in_range = (32'(ref_row) < ROWS) && (32'(ref_col) < COLUMNS);
    assign ref_calc = ADDR_W'(32'(ref_row) * COLUMNS + 32'(ref_col));

    Mat_AddrCal #(
        .COLUMNS (COLUMNS)
    ) u_addr_cal (
        .ref_addr (ref_addr),
        .idx      (idx),
        .addr     (calc_addr)
    );

    assign rd        = (state == ST_ISSUE) && mask[idx];
    assign fb_rd_en  = rd;
    assign fb_addr   = rd ? calc_addr : '0;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign nbr_data  = data_q;
    assign nbr_valid = mask;
    assign err       = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            cap_en  <= 1'b0;
            cap_idx <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cap_en  <= (state == ST_ISSUE);
            cap_idx <= idx;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    idx_nxt   = '0;
                    state_nxt = in_range ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE: begin
                idx_nxt = idx + 3'd1;
                if (idx == 3'(NBR_CNT - 1)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Results are only rewritten from an accepted start onwards, so they stay
    // stable from done until the next request. Slots of skipped neighbours
    // are written 0 rather than whatever the bus carries that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_addr <= '0;
            mask     <= '0;
            err_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            if (accept) begin
                ref_addr <= ref_calc;
                err_q    <= !in_range;
                mask     <= in_range ? nbr_mask(ref_row, ref_col, ROWS, COLUMNS) : '0;
                if (!in_range) begin
                    data_q <= '0;
                end
            end
            if (cap_en) begin
                data_q[cap_idx*PIX_W +: PIX_W] <= mask[cap_idx] ? fb_rd_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_mat_adj_fetch_ctrl.sv
// Self-checking bench for mat_adj_fetch_ctrl: table of directed requests,
// hand sequences for ignored start and mid-fetch reset, and random requests
// checked against a row/column geometry model.
module tb_mat_adj_fetch_ctrl;

    localparam int COLS   = 180;
    localparam int ROWS_N = 120;
    localparam int PW     = 8;

    typedef struct packed {
        logic [6:0]       row;
        logic [7:0]       col;
        logic             err;
        logic [7:0]       valid;
        logic [7:0][14:0] addr;   // element k = address of neighbour k
        logic [3:0]       dn;     // cycle of done relative to accepting edge
    } vec_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [6:0]       ref_row;
    logic [7:0]       ref_col;
    logic             fb_rd_en;
    logic [14:0]      fb_addr;
    logic [PW-1:0]    fb_rd_data;
    logic [8*PW-1:0]  nbr_data;
    logic [7:0]       nbr_valid;
    logic             busy;
    logic             done;
    logic             err;

    int vec_cnt = 0;
    int miss    = 0;

    always #5 clk = ~clk;

    mat_adj_fetch_ctrl #(
        .COLUMNS (COLS),
        .ROWS    (ROWS_N),
        .PIX_W   (PW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .ref_row    (ref_row),
        .ref_col    (ref_col),
        .fb_rd_en   (fb_rd_en),
        .fb_addr    (fb_addr),
        .fb_rd_data (fb_rd_data),
        .nbr_data   (nbr_data),
        .nbr_valid  (nbr_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    function automatic logic [7:0] pix(input logic [14:0] a);
        return a[7:0] ^ {a[14:8], 1'b1};
    endfunction

    // Frame buffer: one-cycle latency, junk on the bus when not reading.
    always @(posedge clk) begin
        if (fb_rd_en) fb_rd_data <= pix(fb_addr);
        else          fb_rd_data <= 8'hEE;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Geometry model: neighbour position from row/column deltas.
    function automatic vec_t model(input int row, input int col);
        int   dr[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
        int   dc[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
        vec_t v;
        int   nr;
        int   nc;
        v       = '0;
        v.row   = 7'(row);
        v.col   = 8'(col);
        v.err   = (row >= ROWS_N) || (col >= COLS);
        v.dn    = v.err ? 4'd1 : 4'd10;
        if (!v.err) begin
            for (int k = 0; k < 8; k++) begin
                nr = row + dr[k];
                nc = col + dc[k];
                if (nr >= 0 && nr < ROWS_N && nc >= 0 && nc < COLS) begin
                    v.valid[k] = 1'b1;
                    v.addr[k]  = 15'(nr * COLS + nc);
                end
            end
        end
        return v;
    endfunction

    function automatic int pick(input int maxv, input int lim);
        case ($urandom_range(0, 4))
            0:       return 0;
            1:       return lim - 1;
            2:       return lim;
            3:       return int'($urandom_range(0, maxv));
            default: return int'($urandom_range(1, lim - 2));
        endcase
    endfunction

    task automatic run_req(input vec_t v, input int restart_at);
        int          rr[$];
        logic [14:0] ra[$];
        int          done_rel  = 0;
        int          busy_bad  = 0;
        int          zero_bad  = 0;
        int          exp_n     = 0;
        int          j         = 0;
        int          extra     = 0;
        int          held_bad  = 0;
        int          n_idle;
        logic [63:0] exp_data  = '0;

        for (int k = 0; k < 8; k++) begin
            if (v.valid[k]) begin
                exp_n++;
                exp_data[k*8 +: 8] = pix(v.addr[k]);
            end
        end

        @(negedge clk);
        start   = 1'b1;
        ref_row = v.row;
        ref_col = v.col;
        @(posedge clk);
        #1;
        start   = 1'b0;
        ref_row = 7'($urandom);
        ref_col = 8'($urandom);

        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == restart_at) begin
                start   = 1'b1;
                ref_row = 7'd50;
                ref_col = 8'd60;
            end else begin
                start = 1'b0;
            end
            if (!busy) busy_bad++;
            if (fb_rd_en) begin
                rr.push_back(c);
                ra.push_back(fb_addr);
            end else if (fb_addr != 15'd0) begin
                zero_bad++;
            end
            if (done) begin
                done_rel = c;
                break;
            end
        end
        start = 1'b0;

        chk("done_cycle", 64'(done_rel), 64'(v.dn));
        chk("busy_during_fetch", 64'(busy_bad), 64'd0);
        chk("addr_zero_when_idle", 64'(zero_bad), 64'd0);
        chk("read_count", 64'(rr.size()), 64'(exp_n));
        for (int k = 0; k < 8; k++) begin
            if (v.valid[k]) begin
                if (j < rr.size()) begin
                    chk("read_cycle", 64'(rr[j]), 64'(k + 1));
                    chk("read_addr", 64'(ra[j]), 64'(v.addr[k]));
                end
                j++;
            end
        end
        chk("nbr_valid", 64'(nbr_valid), 64'(v.valid));
        chk("err", 64'(err), 64'(v.err));
        chk("nbr_data", nbr_data, exp_data);

        n_idle = (restart_at != 0) ? 14 : 3;
        for (int i = 0; i < n_idle; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
            if (nbr_data !== exp_data || nbr_valid !== v.valid || err !== v.err) held_bad++;
        end
        chk("single_done_then_idle", 64'(extra), 64'd0);
        chk("results_held", 64'(held_bad), 64'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {fb_rd_en, fb_addr, nbr_data, nbr_valid, busy, done, err}, '0);
    endtask

    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_done;

        // {row, col, err, valid, addr[7..0], done cycle}
        tbl[0] = '{7'd10, 8'd20, 1'b0, 8'hFF,
                   {15'd1639, 15'd1819, 15'd1999, 15'd2000, 15'd2001, 15'd1821, 15'd1641, 15'd1640}, 4'd10};
        tbl[1] = '{7'd0, 8'd0, 1'b0, 8'b00011100,
                   {15'd0, 15'd0, 15'd0, 15'd180, 15'd181, 15'd1, 15'd0, 15'd0}, 4'd10};
        tbl[2] = '{7'd119, 8'd179, 1'b0, 8'b11000001,
                   {15'd21418, 15'd21598, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd21419}, 4'd10};
        tbl[3] = '{7'd120, 8'd0, 1'b1, 8'h00, '0, 4'd1};
        tbl[4] = '{7'd5, 8'd180, 1'b1, 8'h00, '0, 4'd1};
        tbl[5] = '{7'd0, 8'd179, 1'b0, 8'b01110000,
                   {15'd0, 15'd178, 15'd358, 15'd359, 15'd0, 15'd0, 15'd0, 15'd0}, 4'd10};
        tbl[6] = '{7'd119, 8'd0, 1'b0, 8'b00000111,
                   {15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd21421, 15'd21241, 15'd21240}, 4'd10};

        reset_n = 1'b0;
        start   = 1'b0;
        ref_row = '0;
        ref_col = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_req(tbl[i], 0);
        end

        // Start arriving 3 cycles into a fetch must be ignored.
        run_req(tbl[0], 3);

        // Reset during ISSUE index 4 aborts the fetch with no done.
        @(negedge clk);
        start   = 1'b1;
        ref_row = 7'd10;
        ref_col = 8'd20;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("rd_en_before_reset", 64'(fb_rd_en), 64'd1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("outputs_cleared_by_reset");
        @(negedge clk);
        reset_n  = 1'b1;
        cnt_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy || fb_rd_en) cnt_done++;
        end
        chk("no_activity_after_abort", 64'(cnt_done), 64'd0);
        run_req(tbl[0], 0);

        for (int i = 0; i < 30; i++) begin
            run_req(model(pick(127, ROWS_N), pick(255, COLS)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss);
        $finish;
    end

endmodule
